// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM responder: command encodings,
// burst geometry and the controller state encoding.
package burst_ram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int BURST_BEATS   = 4;
    localparam int DATA_BITWIDTH = 64;
    localparam int MASK_BITWIDTH = DATA_BITWIDTH / 8;

    typedef enum logic [2:0] {
        ST_CALIB,
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ
    } state_t;

endpackage

// File: rtl/burst_ram_mem.sv
// Single-port, synchronous-read, byte-enable RAM of 2^DEPTH_BITWIDTH x 64.
// Coded in the plain block-RAM template: one port, registered read data.
module burst_ram_mem
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 12
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [MASK_BITWIDTH-1:0]  i_be,
    input  logic [DEPTH_BITWIDTH-1:0] i_addr,
    input  logic [DATA_BITWIDTH-1:0]  i_wdata,
    output logic [DATA_BITWIDTH-1:0]  o_rdata
);

    logic [DATA_BITWIDTH-1:0] r_mem [2**DEPTH_BITWIDTH];

    // Byte-enabled write and registered read on the same address port.
    // NOTE: no reset here on purpose -- a reset term on the array or its read
    // register stops block-RAM inference, and contents must survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < MASK_BITWIDTH; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/burst_ram.sv
// Block-RAM-backed responder for the 64-bit burst RAM command interface.
// Fixed 4-beat bursts, fixed read latency, calibration delay after reset.
// Optional feature: define BURST_RAM_PROTOCOL_CHECK_EN to enable the sticky
// protocol_error checker; otherwise protocol_error is tied low.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH   = 12,
    parameter int ADDRESS_BITWIDTH = 21,
    parameter int READ_LATENCY     = 4,
    parameter int CALIB_CYCLES     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        br_cmd,
    input  logic                        br_cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0] br_addr,
    input  logic [DATA_BITWIDTH-1:0]    br_wr_data,
    input  logic [MASK_BITWIDTH-1:0]    br_data_mask,
    output logic [DATA_BITWIDTH-1:0]    br_rd_data,
    output logic                        br_rd_data_valid,
    output logic                        br_init_calib,
    output logic                        busy,
    output logic                        protocol_error
);

    // r_rel counts cycles since the accepted command (1 in the cycle after it);
    // it must reach READ_LATENCY+3 (at most 18).
    localparam int REL_W   = 5;
    localparam int CALIB_W = $clog2(CALIB_CYCLES + 1);

    localparam logic [REL_W-1:0]   REL_WRITE_END   = REL_W'(BURST_BEATS - 1);
    localparam logic [REL_W-1:0]   REL_WAIT_END    = REL_W'(READ_LATENCY - 1);
    localparam logic [REL_W-1:0]   REL_READ_END    = REL_W'(READ_LATENCY + BURST_BEATS - 1);
    // Reads are issued two cycles ahead of the beat: one for the RAM read
    // register, one for the br_rd_data output register.
    localparam logic [REL_W-1:0]   REL_FIRST_ISSUE = REL_W'(READ_LATENCY - 2);
    localparam logic [REL_W-1:0]   REL_LAST_ISSUE  = REL_W'(READ_LATENCY + BURST_BEATS - 3);
    localparam logic [CALIB_W-1:0] CALIB_LAST      = CALIB_W'(CALIB_CYCLES - 1);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [CALIB_W-1:0]         r_calib_cnt;
    logic [REL_W-1:0]           r_rel;
    logic [DEPTH_BITWIDTH-1:0]  r_addr;
    logic                       r_q_valid;
    logic                       w_accept;
    logic                       w_mem_we;
    logic                       w_read_issue;
    logic [DEPTH_BITWIDTH-1:0]  w_mem_addr;
    logic [MASK_BITWIDTH-1:0]   w_mem_be;
    logic [DATA_BITWIDTH-1:0]   w_mem_rdata;
    logic                       w_unused_addr_hi;

    // Address bits above the memory depth are ignored.
    assign w_unused_addr_hi = ^br_addr[ADDRESS_BITWIDTH-1:DEPTH_BITWIDTH];

    assign w_accept      = (r_state == ST_IDLE) && br_cmd_en;
    assign busy          = (r_state != ST_IDLE);
    assign br_init_calib = (r_state != ST_CALIB);
    assign w_mem_be      = ~br_data_mask;

    // Controller state register; reset always returns to calibration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CALIB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    // NOTE: default assigned first so every path through the case drives
    // w_next_state and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CALIB:     if (r_calib_cnt == CALIB_LAST) w_next_state = ST_IDLE;
            ST_IDLE: begin
                if (br_cmd_en) begin
                    w_next_state = (br_cmd == CMD_WRITE) ? ST_WRITE : ST_READ_WAIT;
                end
            end
            ST_WRITE:     if (r_rel == REL_WRITE_END) w_next_state = ST_IDLE;
            ST_READ_WAIT: if (r_rel == REL_WAIT_END)  w_next_state = ST_READ;
            ST_READ:      if (r_rel == REL_READ_END)  w_next_state = ST_IDLE;
            default:      w_next_state = ST_CALIB;
        endcase
    end

    // Calibration counter, burst cycle counter and latched burst base address.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calib_cnt <= '0;
            r_rel       <= '0;
            r_addr      <= '0;
        end else begin
            if (r_state == ST_CALIB) begin
                r_calib_cnt <= r_calib_cnt + 1'b1;
            end
            if (w_accept) begin
                r_rel  <= REL_W'(1);
                r_addr <= br_addr[DEPTH_BITWIDTH-1:0];
            end else if (r_state inside {ST_WRITE, ST_READ_WAIT, ST_READ}) begin
                r_rel <= r_rel + 1'b1;
            end
        end
    end

    // RAM port control: write enables, read issue window and beat address.
    always_comb begin
        w_mem_we     = 1'b0;
        w_read_issue = 1'b0;
        w_mem_addr   = r_addr;
        case (r_state)
            ST_IDLE: begin
                w_mem_addr   = br_addr[DEPTH_BITWIDTH-1:0];
                w_mem_we     = br_cmd_en && (br_cmd == CMD_WRITE);
                w_read_issue = br_cmd_en && (br_cmd == CMD_READ) && (READ_LATENCY == 2);
            end
            ST_WRITE: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_addr + DEPTH_BITWIDTH'(r_rel);
            end
            ST_READ_WAIT, ST_READ: begin
                w_read_issue = (r_rel >= REL_FIRST_ISSUE) && (r_rel <= REL_LAST_ISSUE);
                w_mem_addr   = r_addr + DEPTH_BITWIDTH'(r_rel - REL_FIRST_ISSUE);
            end
            default: ;
        endcase
    end

    burst_ram_mem #(
        .DEPTH_BITWIDTH (DEPTH_BITWIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (w_mem_be),
        .i_addr  (w_mem_addr),
        .i_wdata (br_wr_data),
        .o_rdata (w_mem_rdata)
    );

    // Read return pipeline: RAM data valid one cycle after issue, then
    // registered onto br_rd_data, which holds its value between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_valid        <= 1'b0;
            br_rd_data_valid <= 1'b0;
            br_rd_data       <= '0;
        end else begin
            r_q_valid        <= w_read_issue;
            br_rd_data_valid <= r_q_valid;
            if (r_q_valid) begin
                br_rd_data <= w_mem_rdata;
            end
        end
    end

`ifdef BURST_RAM_PROTOCOL_CHECK_EN
    logic r_protocol_error;

    // Sticky flag: command while busy (calibration included) or unknown br_cmd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_protocol_error <= 1'b0;
        end else if (br_cmd_en && (busy || $isunknown(br_cmd))) begin
            r_protocol_error <= 1'b1;
        end
    end

    assign protocol_error = r_protocol_error;
`else
    assign protocol_error = 1'b0;
`endif

endmodule
